// File: rtl/mem_access_stage.sv
// MEM stage: takes the instruction held in EXE/MEM, runs the data-memory
// load/store over a req/gnt/rvalid bus and registers the write-back result
// into the MEM/WB boundary. ALU-only instructions pass through in one cycle;
// memory instructions hold the upstream stages via mem_stall until done.
module mem_access_stage #(
    parameter logic CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        DataMemWE,
    input  logic        WriteDataSrc,
    input  logic        RegWE,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] ALURes,
    input  logic [31:0] Reg2DataOut,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        RegWE_out,
    output logic [4:0]  WriteReg_out,
    output logic [31:0] WriteData_out,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    // Operands captured at accept; only the word address is kept since the
    // bus is word-addressed and the byte offset has already been checked.
    typedef struct packed {
        logic        isStore;
        logic        regWe;
        logic [4:0]  writeReg;
        logic [29:0] wordAddr;
        logic [31:0] wdata;
    } memOp_t;

    state_t state, stateNext;
    memOp_t op;

    logic accept;
    logic isMem;
    logic misaligned;

    assign accept     = (state == IDLE) && in_valid;
    assign isMem      = DataMemWE | WriteDataSrc;
    assign misaligned = CHECK_ALIGN && (ALURes[1:0] != 2'b00);

    assign mem_stall  = (state != IDLE);
    assign dmem_req   = (state == REQ);
    assign dmem_we    = op.isStore;
    assign dmem_addr  = {op.wordAddr, 2'b00};
    assign dmem_wdata = op.wdata;

    // Next-state logic: only aligned memory ops leave IDLE; stores skip RESP.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept && isMem && !misaligned) stateNext = REQ;
            REQ:  if (dmem_gnt) stateNext = op.isStore ? IDLE : RESP;
            RESP: if (dmem_rvalid) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding bus transaction.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // Operand latch. A store with WriteDataSrc also set stays a store and
    // never writes the register file.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op <= '0;
        end else if (accept) begin
            op.isStore  <= DataMemWE;
            op.regWe    <= RegWE & ~DataMemWE;
            op.writeReg <= WriteReg;
            op.wordAddr <= ALURes[31:2];
            op.wdata    <= Reg2DataOut;
        end
    end

    // MEM/WB boundary: wb_valid, RegWE_out and misalign_err are single-cycle
    // pulses; the register index and data hold between completions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid      <= 1'b0;
            RegWE_out     <= 1'b0;
            misalign_err  <= 1'b0;
            WriteReg_out  <= '0;
            WriteData_out <= '0;
        end else begin
            wb_valid     <= 1'b0;
            RegWE_out    <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !isMem) begin
                        wb_valid      <= 1'b1;
                        RegWE_out     <= RegWE;
                        WriteReg_out  <= WriteReg;
                        WriteData_out <= ALURes;
                    end else if (accept && misaligned) begin
                        wb_valid     <= 1'b1;
                        misalign_err <= 1'b1;
                        WriteReg_out <= WriteReg;
                    end
                end
                REQ: begin
                    if (dmem_gnt && op.isStore) begin
                        wb_valid     <= 1'b1;
                        WriteReg_out <= op.writeReg;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        wb_valid      <= 1'b1;
                        RegWE_out     <= op.regWe;
                        WriteReg_out  <= op.writeReg;
                        WriteData_out <= dmem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: scenario tasks drive stimulus and push the
// expected write-backs; a negedge monitor pops and compares them.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, DataMemWE, WriteDataSrc, RegWE;
    logic [4:0]  WriteReg;
    logic [31:0] ALURes, Reg2DataOut;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid, RegWE_out, misalign_err;
    logic [4:0]  WriteReg_out;
    logic [31:0] WriteData_out;

    // second instance with alignment checking disabled
    logic        ncStall, ncReq, ncWe, ncWb, ncRegWe, ncMis;
    logic [31:0] ncAddr, ncWdata, ncData;
    logic [4:0]  ncReg;
    logic        ncGnt = 1'b1;
    logic        ncRvalid = 1'b1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        regWe;
        logic [4:0]  wreg;
        logic [31:0] data;
        logic        mis;
        logic        chkData;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_stage #(.CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .DataMemWE(DataMemWE),
        .WriteDataSrc(WriteDataSrc), .RegWE(RegWE), .WriteReg(WriteReg),
        .ALURes(ALURes), .Reg2DataOut(Reg2DataOut), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .RegWE_out(RegWE_out),
        .WriteReg_out(WriteReg_out), .WriteData_out(WriteData_out),
        .misalign_err(misalign_err)
    );

    mem_access_stage #(.CHECK_ALIGN(1'b0)) dutNc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .DataMemWE(DataMemWE),
        .WriteDataSrc(WriteDataSrc), .RegWE(RegWE), .WriteReg(WriteReg),
        .ALURes(ALURes), .Reg2DataOut(Reg2DataOut), .mem_stall(ncStall),
        .dmem_req(ncReq), .dmem_we(ncWe), .dmem_addr(ncAddr),
        .dmem_wdata(ncWdata), .dmem_gnt(ncGnt), .dmem_rvalid(ncRvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(ncWb), .RegWE_out(ncRegWe),
        .WriteReg_out(ncReg), .WriteData_out(ncData), .misalign_err(ncMis)
    );

    // Scoreboard monitor: every wb_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && wb_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_wb: wb_valid=1 with no instruction outstanding (reg=%0d data=%h)",
                         WriteReg_out, WriteData_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (RegWE_out !== e.regWe || misalign_err !== e.mis ||
                    (e.chkData && (WriteReg_out !== e.wreg || WriteData_out !== e.data))) begin
                    fails++;
                    $display("FAIL wb_result: got we=%b mis=%b reg=%0d data=%h, want we=%b mis=%b reg=%0d data=%h",
                             RegWE_out, misalign_err, WriteReg_out, WriteData_out,
                             e.regWe, e.mis, e.wreg, e.data);
                end
            end
        end else if (rst === 1'b1) begin
            checks++;
            if (wb_valid !== 1'b0 || RegWE_out !== 1'b0 || misalign_err !== 1'b0) begin
                fails++;
                $display("FAIL idle_pulses: wb_valid=%b RegWE_out=%b misalign_err=%b, want 0 0 0",
                         wb_valid, RegWE_out, misalign_err);
            end
        end
    end

    task automatic setInstr(input logic we, input logic src, input logic rwe,
                            input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1; DataMemWE = we; WriteDataSrc = src; RegWE = rwe;
        WriteReg = r; ALURes = a; Reg2DataOut = d;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        setInstr(1'b0, 1'b0, 1'b1, 5'd5, 32'h55, 32'h0);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b0 || RegWE_out !== 1'b0 || WriteData_out !== 32'h0 ||
                WriteReg_out !== 5'd0 || misalign_err !== 1'b0 || dmem_req !== 1'b0 ||
                mem_stall !== 1'b0 || dmem_addr !== 32'h0 || dmem_we !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: wb=%b we=%b data=%h reg=%0d mis=%b req=%b stall=%b addr=%h, want all 0",
                         wb_valid, RegWE_out, WriteData_out, WriteReg_out, misalign_err,
                         dmem_req, mem_stall, dmem_addr);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        idleCycles(2);
    endtask

    task automatic test_alu_stream;
        for (int i = 0; i < 4; i++) begin
            setInstr(1'b0, 1'b0, 1'b1, 5'(i + 1), 32'h10 + 32'(i), 32'hFFFF_FFFF);
            sb.push_back('{1'b1, 5'(i + 1), 32'h10 + 32'(i), 1'b0, 1'b1});
            @(negedge clk);
            checks++;
            if (mem_stall !== 1'b0 || (i > 0 && wb_valid !== 1'b1)) begin
                fails++;
                $display("FAIL alu_stream[%0d]: stall=%b wb=%b, want stall=0 wb=%b",
                         i, mem_stall, wb_valid, i > 0);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || mem_stall !== 1'b0) begin
            fails++;
            $display("FAIL alu_stream_last: wb=%b stall=%b, want wb=1 stall=0", wb_valid, mem_stall);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL alu_stream_end: wb=%b, want 0", wb_valid);
        end
        idleCycles(1);
    endtask

    task automatic test_load_delayed;
        int stallCycles = 0;
        setInstr(1'b0, 1'b1, 1'b1, 5'd7, 32'h104, 32'h0);
        sb.push_back('{1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1});
        @(posedge clk); #1;
        // junk ALU op on in_valid while busy must be ignored
        setInstr(1'b0, 1'b0, 1'b1, 5'd30, 32'hBAD0_0000, 32'h0);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) dmem_gnt = 1'b1;
            @(negedge clk);
            stallCycles += int'(mem_stall);
            checks++;
            if (dmem_req !== 1'b1 || dmem_addr !== 32'h104 || dmem_we !== 1'b0 || wb_valid !== 1'b0) begin
                fails++;
                $display("FAIL load_req[%0d]: req=%b addr=%h we=%b wb=%b, want req=1 addr=00000104 we=0 wb=0",
                         c, dmem_req, dmem_addr, dmem_we, wb_valid);
            end
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
            @(negedge clk);
            stallCycles += int'(mem_stall);
            checks++;
            if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
                fails++;
                $display("FAIL load_resp[%0d]: req=%b wb=%b, want 0 0", c, dmem_req, wb_valid);
            end
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || mem_stall !== 1'b0 || stallCycles != 6) begin
            fails++;
            $display("FAIL load_done: wb=%b stall=%b stallCycles=%0d, want wb=1 stall=0 stallCycles=6",
                     wb_valid, mem_stall, stallCycles);
        end
        idleCycles(1);
    endtask

    task automatic test_store;
        dmem_gnt = 1'b1;
        // WriteDataSrc also set: still a store, RegWE must be dropped
        setInstr(1'b1, 1'b1, 1'b1, 5'd12, 32'h200, 32'h1234_5678);
        sb.push_back('{1'b0, 5'd12, 32'h0, 1'b0, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200 ||
            dmem_wdata !== 32'h1234_5678 || mem_stall !== 1'b1 || wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h stall=%b wb=%b, want 1 1 00000200 12345678 1 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall, wb_valid);
        end
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL store_done: wb=%b stall=%b req=%b, want 1 0 0", wb_valid, mem_stall, dmem_req);
        end
        idleCycles(1);
    endtask

    task automatic test_misalign;
        setInstr(1'b0, 1'b1, 1'b1, 5'd9, 32'h103, 32'h0);
        sb.push_back('{1'b0, 5'd9, 32'h0, 1'b1, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || misalign_err !== 1'b1 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            fails++;
            $display("FAIL misalign_check: wb=%b mis=%b req=%b stall=%b, want 1 1 0 0",
                     wb_valid, misalign_err, dmem_req, mem_stall);
        end
        checks++;
        if (ncReq !== 1'b1 || ncAddr !== 32'h100 || ncMis !== 1'b0) begin
            fails++;
            $display("FAIL misalign_nocheck: req=%b addr=%h mis=%b, want req=1 addr=00000100 mis=0",
                     ncReq, ncAddr, ncMis);
        end
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || misalign_err !== 1'b0) begin
            fails++;
            $display("FAIL misalign_after: req=%b mis=%b, want 0 0", dmem_req, misalign_err);
        end
        idleCycles(3);
    endtask

    task automatic test_reset_mid;
        dmem_gnt = 1'b1;
        setInstr(1'b0, 1'b1, 1'b1, 5'd4, 32'h300, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL resp_entry: stall=%b req=%b, want 1 0", mem_stall, dmem_req);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_CAFE;
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || wb_valid !== 1'b0 || WriteData_out !== 32'h0 || dmem_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid: stall=%b wb=%b data=%h addr=%h, want 0 0 0 0",
                     mem_stall, wb_valid, WriteData_out, dmem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
            fails++;
            $display("FAIL stray_rvalid: wb=%b stall=%b, want 0 0", wb_valid, mem_stall);
        end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        setInstr(1'b0, 1'b0, 1'b1, 5'd3, 32'h55, 32'h0);
        sb.push_back('{1'b1, 5'd3, 32'h55, 1'b0, 1'b1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || WriteData_out !== 32'h55) begin
            fails++;
            $display("FAIL after_reset_accept: wb=%b data=%h, want 1 00000055", wb_valid, WriteData_out);
        end
        idleCycles(2);
    endtask

    initial begin
        test_reset;
        test_alu_stream;
        test_load_delayed;
        test_store;
        test_misalign;
        test_reset_mid;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d write-backs never seen, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
